// File: rtl/dbg_hub.sv
// dbg_hub: debug controller between the host debug bus and the MCS-4 core/ROM/RAM.
//   Owns subsystem resets, CPU run/halt/step control with PC breakpoints, register
//   readback, and routes ROM/RAM debug traffic. Every read returns one cycle later.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   dbg_req/wen/addr/wdata        host bus request, addr = {seg, ofs}
//   dbg_rdata/dbg_rvalid          read response, one cycle after the read request
//   mem_addr/mem_wdata            shared ROM/RAM debug address and write data
//   rom_wen/ram_wen               memory write strobes
//   rom_rdata/ram_rdata           synchronous memory read data
//   cpu_rst/rom_rst/ram_rst       subsystem resets
//   cpu_stall                     holds the CPU while halted
//   instr_done/pc/instr/idx_reg   CPU retire strobe and observed state
// Optional build: define DBG_HUB_TRACE_EN for the PC trace ring (CTL 0x30-0x32).

// One breakpoint comparator; instanced once per breakpoint.
module dbg_hub_bp #(
  parameter int PC_W = 12
) (
  input  logic [PC_W-1:0] pc,
  input  logic [11:0]     bp_pc,
  input  logic            en,
  output logic            hit
);
  assign hit = en && (pc == PC_W'(bp_pc));
endmodule

module dbg_hub #(
  parameter int SEG_W       = 2,
  parameter int OFS_W       = 12,
  parameter int PC_W        = 12,
  parameter int NUM_REGS    = 16,
  parameter int NUM_BP      = 4,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dbg_req,
  input  logic                  dbg_wen,
  input  logic [SEG_W+OFS_W-1:0] dbg_addr,
  input  logic [7:0]            dbg_wdata,
  output logic [7:0]            dbg_rdata,
  output logic                  dbg_rvalid,
  output logic [OFS_W-1:0]      mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  rom_wen,
  output logic                  ram_wen,
  input  logic [7:0]            rom_rdata,
  input  logic [7:0]            ram_rdata,
  output logic                  cpu_rst,
  output logic                  rom_rst,
  output logic                  ram_rst,
  output logic                  cpu_stall,
  input  logic                  instr_done,
  input  logic [PC_W-1:0]       pc,
  input  logic [7:0]            instr,
  input  logic [NUM_REGS*4-1:0] idx_reg
);
  typedef enum logic [1:0] {RUN = 2'd0, HALT_PEND = 2'd1, HALTED = 2'd2, STEP = 2'd3} state_t;

  logic [SEG_W-1:0] seg;
  logic [OFS_W-1:0] ofs;
  logic             rd_req, wr_ctl, rd_ctl;
  assign seg    = dbg_addr[OFS_W +: SEG_W];
  assign ofs    = dbg_addr[OFS_W-1:0];
  assign rd_req = dbg_req & ~dbg_wen;
  assign wr_ctl = dbg_req & dbg_wen & (seg == SEG_W'(0));
  assign rd_ctl = rd_req & (seg == SEG_W'(0));

  assign mem_addr  = ofs;
  assign mem_wdata = dbg_wdata;
  assign rom_wen   = dbg_req & dbg_wen & (seg == SEG_W'(1));
  assign ram_wen   = dbg_req & dbg_wen & (seg == SEG_W'(2));

  // RUN_CTL decode with priority halt > step > run
  logic run_ctl_wr, halt_w, step_w, run_w;
  assign run_ctl_wr = wr_ctl & (ofs == OFS_W'(1));
  assign halt_w     = run_ctl_wr & dbg_wdata[0];
  assign step_w     = run_ctl_wr & ~dbg_wdata[0] & dbg_wdata[2];
  assign run_w      = run_ctl_wr & ~dbg_wdata[0] & ~dbg_wdata[2] & dbg_wdata[1];

  // control registers
  logic [7:0]               step_cnt;
  logic [NUM_BP-1:0][11:0]  bp_pc;
  logic [NUM_BP-1:0]        bp_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      {ram_rst, rom_rst, cpu_rst} <= 3'b111;
      step_cnt <= '0;
      bp_pc    <= '0;
      bp_en    <= '0;
    end else if (wr_ctl) begin
      if (ofs == OFS_W'(0)) {ram_rst, rom_rst, cpu_rst} <= dbg_wdata[2:0];
      if (ofs == OFS_W'(2)) step_cnt <= dbg_wdata;
      for (int k = 0; k < NUM_BP; k++) begin
        if (ofs == OFS_W'(16 + 2*k)) bp_pc[k][7:0] <= dbg_wdata;
        if (ofs == OFS_W'(17 + 2*k)) begin
          bp_pc[k][11:8] <= dbg_wdata[3:0];
          bp_en[k]       <= dbg_wdata[7];
        end
      end
    end
  end

  // breakpoint match, lowest index wins
  logic [NUM_BP-1:0] bp_vec;
  logic              bp_any;
  logic [2:0]        bp_sel;

  for (genvar g = 0; g < NUM_BP; g++) begin : g_bp
    dbg_hub_bp #(.PC_W(PC_W)) u_bp (
      .pc(pc), .bp_pc(bp_pc[g]), .en(bp_en[g]), .hit(bp_vec[g])
    );
  end

  always_comb begin
    bp_any = |bp_vec;
    bp_sel = 3'd0;
    for (int k = NUM_BP-1; k >= 0; k--)
      if (bp_vec[k]) bp_sel = 3'(k);
  end

  // run control FSM
  state_t     state, state_d;
  logic [7:0] rem, rem_d;
  logic       bp_hit, bp_hit_d;
  logic [2:0] bp_idx, bp_idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= HALTED;
      rem    <= '0;
      bp_hit <= 1'b0;
      bp_idx <= '0;
    end else begin
      state  <= state_d;
      rem    <= rem_d;
      bp_hit <= bp_hit_d;
      bp_idx <= bp_idx_d;
    end
  end

  always_comb begin
    state_d  = state;
    rem_d    = rem;
    bp_hit_d = bp_hit;
    bp_idx_d = bp_idx;
    case (state)
      RUN: begin
        if (halt_w)
          state_d = instr_done ? HALTED : HALT_PEND;
        else if (instr_done && bp_any) begin
          state_d  = HALTED;
          bp_hit_d = 1'b1;
          bp_idx_d = bp_sel;
        end
      end
      HALT_PEND: if (instr_done) state_d = HALTED;
      HALTED: begin
        if (step_w) begin
          state_d  = STEP;
          rem_d    = (step_cnt == 8'd0) ? 8'd1 : step_cnt;
          bp_hit_d = 1'b0;
        end else if (run_w) begin
          state_d  = RUN;
          bp_hit_d = 1'b0;
        end
      end
      STEP: begin
        if (halt_w)
          state_d = instr_done ? HALTED : HALT_PEND;
        else if (instr_done) begin
          rem_d = rem - 8'd1;
          if (rem == 8'd1) state_d = HALTED;
        end
      end
      default: state_d = HALTED;
    endcase
  end

  assign cpu_stall = (state == HALTED);

  // CTL register readback, captured at request time
  logic [15:0] pc16;
  logic [7:0]  ctl_rd;
  assign pc16 = 16'(pc);

`ifdef DBG_HUB_TRACE_EN
  localparam int TR_AW = $clog2(TRACE_DEPTH);
  logic [PC_W-1:0]  tr_mem [TRACE_DEPTH];
  logic [TR_AW-1:0] tr_wp, tr_rp;
  logic [TR_AW:0]   tr_cnt;
  logic             tr_push, tr_pop;
  logic [15:0]      tr_pc16;

  assign tr_push = instr_done && (state != HALTED);
  assign tr_pop  = rd_ctl && (ofs == OFS_W'(8'h32)) && (tr_cnt != '0);
  // oldest entry sits count slots behind the write pointer (equal when full)
  assign tr_rp   = tr_wp - TR_AW'(tr_cnt);
  assign tr_pc16 = (tr_cnt != '0) ? 16'(tr_mem[tr_rp]) : 16'h0;

  always_ff @(posedge clk) begin
    if (tr_push) tr_mem[tr_wp] <= pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tr_wp  <= '0;
      tr_cnt <= '0;
    end else begin
      if (tr_push) tr_wp <= tr_wp + 1'b1;
      if (tr_push && !tr_pop && tr_cnt != (TR_AW+1)'(TRACE_DEPTH))
        tr_cnt <= tr_cnt + 1'b1;
      else if (tr_pop && !tr_push)
        tr_cnt <= tr_cnt - 1'b1;
    end
  end
`endif

  always_comb begin
    ctl_rd = 8'hAA;
    if      (ofs == OFS_W'(0)) ctl_rd = {5'b0, ram_rst, rom_rst, cpu_rst};
    else if (ofs == OFS_W'(1)) ctl_rd = {bp_hit, bp_idx, 2'b00, state};
    else if (ofs == OFS_W'(2)) ctl_rd = step_cnt;
    else if (ofs == OFS_W'(3)) ctl_rd = pc16[7:0];
    else if (ofs == OFS_W'(4)) ctl_rd = pc16[15:8];
    else if (ofs == OFS_W'(5)) ctl_rd = instr;
`ifdef DBG_HUB_TRACE_EN
    else if (ofs == OFS_W'(8'h30)) ctl_rd = 8'(tr_cnt);
    else if (ofs == OFS_W'(8'h31)) ctl_rd = tr_pc16[7:0];
    else if (ofs == OFS_W'(8'h32)) ctl_rd = tr_pc16[15:8];
`endif
    for (int k = 0; k < NUM_BP; k++) begin
      if (ofs == OFS_W'(16 + 2*k)) ctl_rd = bp_pc[k][7:0];
      if (ofs == OFS_W'(17 + 2*k)) ctl_rd = {bp_en[k], 3'b000, bp_pc[k][11:8]};
    end
    for (int p = 0; p < NUM_REGS/2; p++)
      if (ofs == OFS_W'(32 + p)) ctl_rd = {idx_reg[8*p +: 4], idx_reg[8*p+4 +: 4]};
  end

  // read response: one cycle after the request, source chosen by registered seg
  logic             rd_vld_q;
  logic [SEG_W-1:0] rd_seg_q;
  logic [7:0]       ctl_q, rdata_mux;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
      rd_seg_q <= '0;
      ctl_q    <= '0;
    end else begin
      rd_vld_q <= rd_req;
      rd_seg_q <= seg;
      ctl_q    <= ctl_rd;
    end
  end

  always_comb begin
    rdata_mux = 8'hAA;
    if      (rd_seg_q == SEG_W'(0)) rdata_mux = ctl_q;
    else if (rd_seg_q == SEG_W'(1)) rdata_mux = rom_rdata;
    else if (rd_seg_q == SEG_W'(2)) rdata_mux = ram_rdata;
  end

  assign dbg_rvalid = rd_vld_q;
  assign dbg_rdata  = rd_vld_q ? rdata_mux : 8'h00;

endmodule

// File: tb/tb_dbg_hub.sv
// tb_dbg_hub: directed bench for dbg_hub. Reads push their expected byte into a
// scoreboard queue; a negedge monitor pops and compares on every dbg_rvalid.
// A simple CPU model retires one instruction per cycle while not stalled.
module tb_dbg_hub;
  localparam int SEG_W = 2, OFS_W = 12, PC_W = 12, NUM_REGS = 16, NUM_BP = 4, TD = 16;

  logic clk, rst;
  logic dbg_req, dbg_wen;
  logic [13:0] dbg_addr;
  logic [7:0] dbg_wdata, dbg_rdata;
  logic dbg_rvalid;
  logic [11:0] mem_addr;
  logic [7:0] mem_wdata, rom_rdata, ram_rdata;
  logic rom_wen, ram_wen, cpu_rst, rom_rst, ram_rst, cpu_stall, instr_done;
  logic [11:0] pc;
  logic [7:0] instr;
  logic [63:0] idx_reg;

  dbg_hub #(.SEG_W(SEG_W), .OFS_W(OFS_W), .PC_W(PC_W), .NUM_REGS(NUM_REGS),
            .NUM_BP(NUM_BP), .TRACE_DEPTH(TD)) dut (
    .clk(clk), .rst(rst), .dbg_req(dbg_req), .dbg_wen(dbg_wen), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rom_wen(rom_wen), .ram_wen(ram_wen),
    .rom_rdata(rom_rdata), .ram_rdata(ram_rdata), .cpu_rst(cpu_rst), .rom_rst(rom_rst),
    .ram_rst(ram_rst), .cpu_stall(cpu_stall), .instr_done(instr_done), .pc(pc),
    .instr(instr), .idx_reg(idx_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous memories
  logic [7:0] rom_m [0:4095];
  logic [7:0] ram_m [0:4095];
  always @(posedge clk) begin
    if (rom_wen) rom_m[mem_addr] <= mem_wdata;
    if (ram_wen) ram_m[mem_addr] <= mem_wdata;
    rom_rdata <= rom_m[mem_addr];
    ram_rdata <= ram_m[mem_addr];
  end

  int total = 0, bad = 0, nret = 0;
  bit cpu_auto = 0;

  typedef struct { string name; logic [7:0] val; } exp_t;
  exp_t sbq[$];
  exp_t e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dbg_rvalid) begin
      if (sbq.size() == 0) chk("rvalid_no_exp", {31'b0, dbg_rvalid}, 32'd0);
      else begin
        e = sbq.pop_front();
        chk(e.name, {24'b0, dbg_rdata}, {24'b0, e.val});
      end
    end
  end

  // one clock; CPU model retires a new pc each cycle it is not stalled
  task automatic cyc();
    @(posedge clk); #1;
    if (cpu_auto) begin
      if (!cpu_stall) begin
        instr_done = 1'b1;
        pc = pc + 12'd1;
        nret++;
      end else instr_done = 1'b0;
    end
  endtask

  function automatic logic [13:0] ad(input logic [1:0] s, input logic [11:0] o);
    return {s, o};
  endfunction

  task automatic wr(input logic [13:0] a, input logic [7:0] d);
    dbg_req = 1'b1; dbg_wen = 1'b1; dbg_addr = a; dbg_wdata = d;
    cyc();
    dbg_req = 1'b0; dbg_wen = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a, input logic [7:0] x, input string nm);
    dbg_req = 1'b1; dbg_wen = 1'b0; dbg_addr = a;
    sbq.push_back('{name: nm, val: x});
    cyc();
    dbg_req = 1'b0;
    chk({nm, "_rvalid"}, {31'b0, dbg_rvalid}, 32'd1);
  endtask

  task automatic wait_stall(input string nm);
    int n = 0;
    while (!cpu_stall && n < 100) begin cyc(); n++; end
    chk(nm, {31'b0, cpu_stall}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; dbg_req = 0; dbg_wen = 0; dbg_addr = '0; dbg_wdata = '0;
    instr_done = 0; pc = 12'h00B; instr = 8'hD3; idx_reg = 64'hFEDC_BA98_7654_3210;
    repeat (3) cyc();
    rst = 1'b0;

    // reset state
    chk("rst_vec", {29'b0, ram_rst, rom_rst, cpu_rst}, 32'd7);
    chk("rst_stall", {31'b0, cpu_stall}, 32'd1);
    chk("rst_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    chk("rst_rdata", {24'b0, dbg_rdata}, 32'd0);
    rd(ad(0, 12'h000), 8'h07, "sys_rst");
    rd(ad(0, 12'h001), 8'h02, "run_ctl_rst");
    rd(ad(0, 12'h002), 8'h00, "step_cnt_rst");

    // reset release does not move the FSM
    wr(ad(0, 12'h000), 8'h00);
    chk("rst_vec_clr", {29'b0, ram_rst, rom_rst, cpu_rst}, 32'd0);
    chk("stall_after_rstwr", {31'b0, cpu_stall}, 32'd1);
    rd(ad(0, 12'h001), 8'h02, "run_ctl_after_rstwr");

    // register map spot checks
    rd(ad(0, 12'h005), 8'hD3, "instr");
    rd(ad(0, 12'h006), 8'hAA, "unmapped_06");
    rd(ad(0, 12'h020), 8'h01, "idx_pair0");
    rd(ad(0, 12'h027), 8'hEF, "idx_pair7");
    rd(ad(0, 12'h028), 8'hAA, "idx_pair8");
    rd(ad(0, 12'h100), 8'hAA, "unmapped_100");
`ifndef DBG_HUB_TRACE_EN
    rd(ad(0, 12'h030), 8'hAA, "trace_off");
`endif

    // breakpoints: BP0 pc 0x010, BP2 pc 0x00E, BP3 pc 0x00D disabled
    wr(ad(0, 12'h010), 8'h10); wr(ad(0, 12'h011), 8'h80);
    wr(ad(0, 12'h014), 8'h0E); wr(ad(0, 12'h015), 8'h80);
    wr(ad(0, 12'h016), 8'h0D); wr(ad(0, 12'h017), 8'h00);
    rd(ad(0, 12'h010), 8'h10, "bp0_lo");
    rd(ad(0, 12'h011), 8'h80, "bp0_hi");
    cpu_auto = 1;
    wr(ad(0, 12'h001), 8'h02);
    wait_stall("bp2_stall");
    chk("bp2_pc", {20'b0, pc}, 32'h00E);
    rd(ad(0, 12'h001), 8'hA2, "bp2_status");
    wr(ad(0, 12'h001), 8'h02);
    wait_stall("bp0_stall");
    chk("bp0_pc", {20'b0, pc}, 32'h010);
    rd(ad(0, 12'h001), 8'h82, "bp0_status");
    rd(ad(0, 12'h003), 8'h10, "pc_lo");
    rd(ad(0, 12'h004), 8'h00, "pc_hi");
    wr(ad(0, 12'h011), 8'h00); wr(ad(0, 12'h015), 8'h00);

    // stepping
    wr(ad(0, 12'h002), 8'h03);
    rd(ad(0, 12'h002), 8'h03, "step_cnt");
    nret = 0;
    wr(ad(0, 12'h001), 8'h04);
    wait_stall("step3_stall");
    chk("step3_count", nret, 32'd3);
    rd(ad(0, 12'h001), 8'h02, "step_clears_hit");
    wr(ad(0, 12'h002), 8'h00);
    nret = 0;
    wr(ad(0, 12'h001), 8'h04);
    wait_stall("step0_stall");
    chk("step0_count", nret, 32'd1);

    // halt coinciding with a retire goes straight to HALTED
    wr(ad(0, 12'h001), 8'h02);
    cyc(); cyc();
    chk("running", {31'b0, cpu_stall}, 32'd0);
    wr(ad(0, 12'h001), 8'h01);
    chk("halt_direct", {31'b0, cpu_stall}, 32'd1);
    rd(ad(0, 12'h001), 8'h02, "halt_direct_state");

    // halt with no retire waits in HALT_PEND
    cpu_auto = 0; instr_done = 0;
    wr(ad(0, 12'h001), 8'h02);
    wr(ad(0, 12'h001), 8'h01);
    for (int i = 0; i < 4; i++) begin
      rd(ad(0, 12'h001), 8'h01, "halt_pend_state");
      chk("halt_pend_stall", {31'b0, cpu_stall}, 32'd0);
    end
    instr_done = 1; pc = 12'h200;
    cyc();
    instr_done = 0;
    chk("halt_pend_done", {31'b0, cpu_stall}, 32'd1);

    // memory routing
    dbg_req = 1; dbg_wen = 1; dbg_addr = ad(1, 12'h123); dbg_wdata = 8'h5A;
    #1;
    chk("rom_wen_hi", {31'b0, rom_wen}, 32'd1);
    chk("ram_wen_lo", {31'b0, ram_wen}, 32'd0);
    chk("mem_addr", {20'b0, mem_addr}, 32'h123);
    chk("mem_wdata", {24'b0, mem_wdata}, 32'h5A);
    cyc();
    dbg_req = 0; dbg_wen = 0;
    #1;
    chk("rom_wen_pulse", {31'b0, rom_wen}, 32'd0);
    rd(ad(1, 12'h123), 8'h5A, "rom_rd");
    wr(ad(2, 12'h045), 8'h77);
    rd(ad(2, 12'h045), 8'h77, "ram_rd");
    rd(ad(3, 12'h000), 8'hAA, "seg3_rd");
    wr(ad(3, 12'h123), 8'h11);
    rd(ad(1, 12'h123), 8'h5A, "rom_untouched");

    // global reset in the middle of a step
    wr(ad(0, 12'h002), 8'd50);
    cpu_auto = 1;
    wr(ad(0, 12'h001), 8'h04);
    cyc(); cyc(); cyc();
    chk("mid_step_running", {31'b0, cpu_stall}, 32'd0);
    rst = 1;
    cyc();
    rst = 0;
    cpu_auto = 0; instr_done = 0;
    chk("rst_abort_stall", {31'b0, cpu_stall}, 32'd1);
    chk("rst_abort_vec", {29'b0, ram_rst, rom_rst, cpu_rst}, 32'd7);
    rd(ad(0, 12'h001), 8'h02, "rst_abort_state");

`ifdef DBG_HUB_TRACE_EN
    rd(ad(0, 12'h030), 8'h00, "trace_cnt_rst");
    wr(ad(0, 12'h001), 8'h02);
    for (int i = 1; i <= 19; i++) begin
      instr_done = 1; pc = 12'h100 + 12'(i);
      cyc();
    end
    instr_done = 1; pc = 12'h114;
    wr(ad(0, 12'h001), 8'h01);
    instr_done = 0;
    chk("trace_halted", {31'b0, cpu_stall}, 32'd1);
    rd(ad(0, 12'h030), 8'h10, "trace_cnt_full");
    for (int i = 5; i <= 20; i++) begin
      rd(ad(0, 12'h031), 8'(i), "trace_lo");
      rd(ad(0, 12'h032), 8'h01, "trace_hi");
    end
    rd(ad(0, 12'h030), 8'h00, "trace_cnt_empty");
    rd(ad(0, 12'h032), 8'h00, "trace_pop_empty");
    rd(ad(0, 12'h031), 8'h00, "trace_lo_empty");
    rd(ad(0, 12'h030), 8'h00, "trace_cnt_still_0");
`endif

    cyc(); cyc();
    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
